// File: rtl/frame_update_scheduler.sv
// Per-frame sequencer: on each accepted VSYNC fall, issues position, collision and game-state
// stages in order via start/done handshakes, with speed gating, overrun and timeout reporting.
module frame_update_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned FCNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vs,
   input  logic              enable,
   input  logic [2:0]        speed,
   output logic              pos_start,
   input  logic              pos_done,
   output logic              col_start,
   input  logic              col_done,
   output logic              st_start,
   input  logic              st_done,
   output logic              busy,
   output logic              frame_tick,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              overrun,
   output logic              timeout_err,
   input  logic              clear_err
);

   localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StIdle, StPos, StCol, StSt} state_e;

   state_e            state_q, state_d;
   logic              vs_d_q;
   logic [WCNT_W-1:0] wait_q, wait_d;
   logic [2:0]        skip_q, skip_d;
   logic              fall, accept, first, expired, to_set;

   always_comb begin
      fall    = vs_d_q & ~vs;
      accept  = fall && (state_q == StIdle);
      // The first cycle of a stage is the one where the wait counter is still zero.
      first   = (wait_q == '0);
      expired = (wait_q == WCNT_W'(TIMEOUT_CYCLES - 1));
      state_d = state_q;
      to_set  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept && enable) state_d = (skip_q == 3'd0) ? StPos : StCol;
         end
         StPos: begin
            if (!first && pos_done) begin
               state_d = StCol;
            end else if (expired) begin
               state_d = StIdle;
               to_set  = 1'b1;
            end
         end
         StCol: begin
            if (!first && col_done) begin
               state_d = StSt;
            end else if (expired) begin
               state_d = StIdle;
               to_set  = 1'b1;
            end
         end
         StSt: begin
            if (!first && st_done) begin
               state_d = StIdle;
            end else if (expired) begin
               state_d = StIdle;
               to_set  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if ((state_d != state_q) || (state_q == StIdle)) wait_d = '0;
      else                                             wait_d = wait_q + WCNT_W'(1);

      skip_d = skip_q;
      if (!enable) begin
         skip_d = 3'd0;
      end else if (accept) begin
         skip_d = (skip_q >= (3'd7 - speed)) ? 3'd0 : skip_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         vs_d_q      <= 1'b1;
         wait_q      <= '0;
         skip_q      <= 3'd0;
         pos_start   <= 1'b0;
         col_start   <= 1'b0;
         st_start    <= 1'b0;
         busy        <= 1'b0;
         frame_tick  <= 1'b0;
         frame_cnt   <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         vs_d_q     <= vs;
         wait_q     <= wait_d;
         skip_q     <= skip_d;
         pos_start  <= (state_d == StPos) && (state_q != StPos);
         col_start  <= (state_d == StCol) && (state_q != StCol);
         st_start   <= (state_d == StSt) && (state_q != StSt);
         busy       <= (state_d != StIdle);
         frame_tick <= accept;
         if (accept) frame_cnt <= frame_cnt + FCNT_W'(1);
         // Sticky flags: a new event in the clearing cycle wins over clear_err.
         if (fall && (state_q != StIdle)) overrun <= 1'b1;
         else if (clear_err)               overrun <= 1'b0;
         if (to_set)         timeout_err <= 1'b1;
         else if (clear_err) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed and randomized bench for frame_update_scheduler with an automatic done responder.
module tb_frame_update_scheduler;

   localparam int unsigned TO = 16;
   localparam int unsigned FW = 16;

   logic          clk = 1'b0;
   logic          rst_n, vs, enable, clear_err;
   logic [2:0]    speed;
   logic          pos_start, col_start, st_start, pos_done, col_done, st_done;
   logic          busy, frame_tick, overrun, timeout_err;
   logic [FW-1:0] frame_cnt;

   frame_update_scheduler #(.TIMEOUT_CYCLES(TO), .FCNT_W(FW)) dut (
      .clk(clk), .rst_n(rst_n), .vs(vs), .enable(enable), .speed(speed),
      .pos_start(pos_start), .pos_done(pos_done), .col_start(col_start), .col_done(col_done),
      .st_start(st_start), .st_done(st_done), .busy(busy), .frame_tick(frame_tick),
      .frame_cnt(frame_cnt), .overrun(overrun), .timeout_err(timeout_err),
      .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_pos = 0, n_col = 0, n_st = 0, n_tick = 0;
   int pos_cyc = 0, col_cyc = 0, st_cyc = 0;
   int lat[3];
   int rem = 0;
   int stage = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle, record start/tick pulses, and answer starts with dones after lat cycles
   // (lat of 0 withholds the done).
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (frame_tick) n_tick++;
      if (pos_start) begin n_pos++; pos_cyc = cyc; stage = 0; rem = lat[0]; end
      if (col_start) begin n_col++; col_cyc = cyc; stage = 1; rem = lat[1]; end
      if (st_start)  begin n_st++;  st_cyc = cyc;  stage = 2; rem = lat[2]; end
      pos_done = 1'b0;
      col_done = 1'b0;
      st_done  = 1'b0;
      if (!(pos_start || col_start || st_start) && rem > 0) begin
         rem--;
         if (rem == 0) begin
            if (stage == 0) pos_done = 1'b1;
            else if (stage == 1) col_done = 1'b1;
            else st_done = 1'b1;
         end
      end
   endtask

   task automatic fall();
      vs = 1'b0;
      step();
      vs = 1'b1;
   endtask

   task automatic wait_idle(output int t);
      int k = 0;
      while (busy && k < 200) begin
         step();
         k++;
      end
      chk("idle_bound", 32'(busy), 0);
      t = cyc;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; vs = 1'b1; enable = 1'b0; speed = 3'd0; clear_err = 1'b0;
      pos_done = 1'b0; col_done = 1'b0; st_done = 1'b0; rem = 0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int n, t, p0, c0, s0, k0, exp_fcnt, phase, k;
      logic e, exp_pos;
      logic [2:0] sp;
      lat[0] = 1; lat[1] = 1; lat[2] = 1;

      // Reset state
      do_reset();
      chk("reset_outs", 32'({pos_start, col_start, st_start, busy, frame_tick, overrun,
                              timeout_err}), 0);
      chk("reset_fcnt", 32'(frame_cnt), 0);

      // Minimum-latency sequence at speed 7
      speed = 3'd7; enable = 1'b1;
      step();
      n = cyc;
      fall();
      chk("t1_tick", 32'(frame_tick), 1);
      chk("t1_busy", 32'(busy), 1);
      wait_idle(t);
      chk("t1_pos_cyc", pos_cyc, n + 1);
      chk("t1_col_cyc", col_cyc, n + 3);
      chk("t1_st_cyc", st_cyc, n + 5);
      chk("t1_idle_cyc", t, n + 7);
      chk("t1_fcnt", 32'(frame_cnt), 1);

      // Speed 0: position update only every 8th frame
      speed = 3'd0;
      for (int i = 0; i < 16; i++) begin
         p0 = n_pos; c0 = n_col; s0 = n_st;
         step();
         fall();
         wait_idle(t);
         chk("t2_pos", n_pos - p0, (i % 8 == 0) ? 1 : 0);
         chk("t2_col", n_col - c0, 1);
         chk("t2_st", n_st - s0, 1);
      end
      chk("t2_fcnt", 32'(frame_cnt), 17);

      // Collision done withheld: timeout
      speed = 3'd7; lat[1] = 0;
      s0 = n_st;
      step();
      fall();
      wait_idle(t);
      chk("t3_idle_cyc", t, col_cyc + TO);
      chk("t3_timeout", 32'(timeout_err), 1);
      chk("t3_no_st", n_st - s0, 0);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("t3_cleared", 32'(timeout_err), 0);
      lat[1] = 1;

      // Second fall while in COL: overrun
      lat[1] = 5;
      s0 = n_st; c0 = n_col;
      step();
      fall();
      k = 0;
      while (n_col == c0 && k < 20) begin step(); k++; end
      chk("t4_col_seen", n_col - c0, 1);
      k0 = n_tick;
      vs = 1'b0;
      step();
      vs = 1'b1;
      chk("t4_overrun", 32'(overrun), 1);
      wait_idle(t);
      chk("t4_no_tick", n_tick - k0, 0);
      chk("t4_fcnt", 32'(frame_cnt), 19);
      chk("t4_st_done", n_st - s0, 1);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("t4_cleared", 32'(overrun), 0);
      lat[1] = 1;

      // enable low: ticks only; then enable dropped during POS
      do_reset();
      k0 = n_tick; p0 = n_pos; c0 = n_col; s0 = n_st;
      for (int i = 0; i < 3; i++) begin
         fall();
         step();
         step();
      end
      chk("t5_ticks", n_tick - k0, 3);
      chk("t5_fcnt", 32'(frame_cnt), 3);
      chk("t5_no_starts", (n_pos - p0) + (n_col - c0) + (n_st - s0), 0);
      enable = 1'b1; speed = 3'd7;
      step();
      fall();
      chk("t5_pos", 32'(pos_start), 1);
      enable = 1'b0;
      wait_idle(t);
      chk("t5_col", n_col - c0, 1);
      chk("t5_st", n_st - s0, 1);

      // Reset in COL, with skip_cnt nonzero beforehand
      do_reset();
      enable = 1'b1; speed = 3'd0;
      step();
      fall();
      wait_idle(t);
      step();
      p0 = n_pos;
      fall();
      chk("t6_col_direct", 32'(col_start), 1);
      chk("t6_no_pos", n_pos - p0, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_async_outs", 32'({pos_start, col_start, st_start, busy, frame_tick, overrun,
                                 timeout_err}), 0);
      chk("t6_async_fcnt", 32'(frame_cnt), 0);
      rem = 0; pos_done = 1'b0; col_done = 1'b0; st_done = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      fall();
      chk("t6_pos_after", 32'(pos_start), 1);
      wait_idle(t);

      // Randomized frames against a frame-level model
      do_reset();
      exp_fcnt = 0;
      phase = 0;
      for (int i = 0; i < 40; i++) begin
         e = ($urandom_range(0, 3) != 0);
         sp = 3'($urandom_range(0, 7));
         for (int j = 0; j < 3; j++) lat[j] = $urandom_range(1, 4);
         enable = e; speed = sp;
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) step();
         p0 = n_pos; c0 = n_col; s0 = n_st;
         fall();
         exp_fcnt++;
         // Position is due when no enabled frames have passed since the last update window.
         exp_pos = 1'b0;
         if (e) begin
            exp_pos = (phase == 0);
            phase = (phase >= 7 - int'(sp)) ? 0 : phase + 1;
         end else begin
            phase = 0;
         end
         wait_idle(t);
         chk("rnd_pos", n_pos - p0, exp_pos ? 1 : 0);
         chk("rnd_col", n_col - c0, e ? 1 : 0);
         chk("rnd_st", n_st - s0, e ? 1 : 0);
         chk("rnd_fcnt", 32'(frame_cnt), exp_fcnt);
      end
      chk("rnd_no_err", 32'({overrun, timeout_err}), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
